// File: rtl/bcd_display_mux.sv
// bcd_display_mux
// Drives a 4-digit common-anode multiplexed seven-segment display as "S.ttt"
// from four BCD digits. The digits are snapshotted into shadow registers on
// `load`, so the display never shows a half-updated count. One digit is
// scanned per refresh slot. Each slot opens with GUARD cycles of all anodes
// off, which suppresses ghosting from the previous digit.
//
// Ports:
//   clk          system clock, rising edge
//   clear        synchronous active-high reset (priority over load)
//   seconds      BCD digit shown on an[3], followed by the decimal point
//   tenths       BCD digit shown on an[2]
//   hundreths    BCD digit shown on an[1]
//   thousandths  BCD digit shown on an[0]
//   load         copies the four input digits into the shadow registers
//   blank        forces all anodes off; scanning and loading continue
//   an           digit enables, one-hot when active
//   seg          segments {g,f,e,d,c,b,a}
//   dp           decimal point
//
// All outputs are registered. They follow idx/pcnt/shadow/blank with one
// cycle of latency. ACTIVE_LOW selects the pin polarity of an, seg and dp.

module bcd_display_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] seconds,
  input  logic [3:0] tenths,
  input  logic [3:0] hundreths,
  input  logic [3:0] thousandths,
  input  logic       load,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PCNT_LIT  = PW'(GUARD);

  // Pin-level "off" levels. They depend only on polarity.
  localparam logic [3:0] AN_OFF  = {4{ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic [3:0]    sh_s, sh_t, sh_h, sh_th;

  logic [3:0] digit;
  logic [6:0] seg_logic;
  logic [3:0] an_logic;
  logic       dp_logic;

  // Select the shadow digit for the current slot and decode it.
  // Logical (active-high) values are produced here; the pin polarity is
  // applied at the output register.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    digit     = sh_th;
    seg_logic = 7'b1000000;
    an_logic  = 4'b0000;
    dp_logic  = 1'b0;

    unique case (idx)
      2'd0: digit = sh_th;
      2'd1: digit = sh_h;
      2'd2: digit = sh_t;
      2'd3: digit = sh_s;
    endcase

    case (digit)
      4'd0:    seg_logic = 7'b0111111;
      4'd1:    seg_logic = 7'b0000110;
      4'd2:    seg_logic = 7'b1011011;
      4'd3:    seg_logic = 7'b1001111;
      4'd4:    seg_logic = 7'b1100110;
      4'd5:    seg_logic = 7'b1101101;
      4'd6:    seg_logic = 7'b1111101;
      4'd7:    seg_logic = 7'b0000111;
      4'd8:    seg_logic = 7'b1111111;
      4'd9:    seg_logic = 7'b1101111;
      default: seg_logic = 7'b1000000;  // invalid BCD shows a dash
    endcase

    // The anode lights only after the guard interval, and only when not blanked.
    // seg/dp keep tracking the selected digit either way.
    if (!blank && (pcnt >= PCNT_LIT))
      an_logic = 4'b0001 << idx;

    dp_logic = (idx == 2'd3);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (clear) begin
      // NOTE: the shadow digits are four small flop registers, not a RAM, so they are cleared with the rest of the state.
      pcnt  <= '0;
      idx   <= 2'd0;
      sh_s  <= 4'd0;
      sh_t  <= 4'd0;
      sh_h  <= 4'd0;
      sh_th <= 4'd0;
      an    <= AN_OFF;
      seg   <= SEG_OFF;
      dp    <= DP_OFF;
    end else begin
      if (pcnt == PCNT_LAST) begin
        pcnt <= '0;
        idx  <= idx + 2'd1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end

      if (load) begin
        sh_s  <= seconds;
        sh_t  <= tenths;
        sh_h  <= hundreths;
        sh_th <= thousandths;
      end

      an  <= an_logic  ^ AN_OFF;
      seg <= seg_logic ^ SEG_OFF;
      dp  <= dp_logic  ^ DP_OFF;
    end
  end

endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
Consumes the four BCD digits (seconds, tenths, hundreths, thousandths) produced by the timer's BCD counter chain and drives a 4-digit common-anode multiplexed seven-segment display as "S.ttt".
- Snapshots digits into shadow registers on a load strobe, so the display never tears mid-count.
- Scans one digit per refresh slot, with a guard interval of anodes-off at the start of each slot to suppress ghosting.
- Sits between the BCD counter stage and the board display pins.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (50 MHz -> 1 kHz per digit, 250 Hz frame); legal range >= GUARD+2
GUARD, 2, cycles at start of each slot with all anodes off; legal range >= 0
ACTIVE_LOW, 1, 1 = an/seg/dp are active-low at the pins; 0 = active-high

Ports:
clk  in  1  system clock; all state updates on rising edge
clear  in  1  synchronous active-high reset
seconds  in  4  BCD digit, displayed on an[3]
tenths  in  4  BCD digit, displayed on an[2]
hundreths  in  4  BCD digit, displayed on an[1]
thousandths  in  4  BCD digit, displayed on an[0]
load  in  1  1 at a clk edge copies the four input digits into the shadow registers
blank  in  1  1 forces all anodes off; scanning and loading continue
an  out  4  digit enables, one-hot when active
seg  out  7  segments {g,f,e,d,c,b,a}, seg[0] = a
dp  out  1  decimal point

Behaviour:
- Reset: clear=1 at an edge zeroes shadow regs, prescaler (pcnt), and digit index (idx). All outputs are registered; in the cycle after a clear edge, an/seg/dp are all "off" (ACTIVE_LOW=1: an=4'b1111, seg=7'b1111111, dp=1). clear has priority over load.
- Prescaler: pcnt counts 0..REFRESH_DIV-1. At pcnt==REFRESH_DIV-1, pcnt wraps to 0 and idx advances 0->1->2->3->0.
- Shadow regs: load=1 captures all four inputs at that edge; otherwise they hold. load has no effect on pcnt or idx.
- Output register: each edge computes outputs from the current idx, pcnt, shadow and blank (1-cycle latency).
  - Anodes on only if blank==0 and pcnt>=GUARD. The active anode is an[idx]; the others are off.
  - During the guard interval or blank: anodes off; seg/dp still reflect the selected digit.
- Decode (logical, active-high, g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Values 10-15 (invalid BCD) display dash = 1000000.
- dp: logically on only when idx==3 (after the seconds digit).
- Polarity: ACTIVE_LOW=1 inverts an, seg and dp at the output register.
- Sequencing after clear deasserts: the first slot is idx=0. The first GUARD cycles have anodes off, then an[0] is lit until the slot ends.
- Mid-scan load: new digits appear on the next output update; a slot may switch digit value mid-slot (accepted).
- Mid-scan clear: outputs go off the next cycle and the scan restarts at idx=0, pcnt=0.
- No leading-zero suppression: seconds=0 shows "0.".

Test Plan:
Use REFRESH_DIV=4, GUARD=1, ACTIVE_LOW=1 throughout.
1. Reset and scan order: clear for 2 cycles, then load digits 1,2,3,4 (s,t,h,th).
   -> After clear: an=1111, seg=1111111, dp=1.
   -> In each slot, an[] is 1111 for 1 cycle, then the slot anode for 3 cycles, in sequence 1110, 1101, 1011, 0111.
   -> seg on an=1110 is ~0000110 XOR applied to digit 4's pattern, i.e. seg=~1100110=0011001.
   -> dp=0 only while an=0111, where seg=~0000110=1111001.
2. All digits: load each value 0..9 into thousandths.
   -> seg on an[0] equals the inverted decode table entry for every value.
   -> Load 4'hA..4'hF -> seg=0111111 (dash).
3. Hold/snapshot: load 9,9,9,9; then change inputs to 0,0,0,0 with load=0 for 40 cycles.
   -> Display stays at 9 on every digit (seg=0010000).
   -> Pulse load once -> 0 (seg=1000000) appears from the next cycle.
4. Blank: assert blank for 10 cycles mid-scan.
   -> an=1111 throughout; idx still advances, with the same slot sequence/timing as an unblanked run.
   -> Deassert blank -> the anode for the current idx resumes.
5. Simultaneous clear+load with inputs 5,5,5,5.
   -> Shadow stays 0: the first lit digit after the guard shows seg=1000000, not 5.
6. Mid-scan reset: clear during the idx=2 slot.
   -> Next cycle outputs are off.
   -> After release, the guard cycle is followed by an=1110; no partial slot at idx=2 or 3.
